// File: rtl/wb_scr1_arbiter.sv
// rtl/wb_scr1_arbiter.sv - two-master Wishbone classic arbiter with slave timeout
// Define WB_SCR1_ARB_RR_EN for round-robin on simultaneous requests (default: m1 wins).
module wb_scr1_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  output logic [31:0] wbs_adr_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  wbs_sel_o,
  input  logic [31:0] wbs_dat_i,
  input  logic        wbs_ack_i
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        grant;
  logic        last_grant;
  logic [15:0] wait_cnt;
  logic        req0;
  logic        req1;
  logic        pick;
  logic        grant_cyc;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

`ifdef WB_SCR1_ARB_RR_EN
  assign pick = (req0 & req1) ? ~last_grant : req1;
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign pick = req1;
`endif

  // Dropping cyc mid-transfer is how a master abandons its granted cycle.
  assign grant_cyc = grant ? m1_cyc_i : m0_cyc_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b0;
      wait_cnt   <= 16'd0;
      wbs_cyc_o  <= 1'b0;
      wbs_stb_o  <= 1'b0;
      wbs_we_o   <= 1'b0;
      wbs_adr_o  <= 32'd0;
      wbs_dat_o  <= 32'd0;
      wbs_sel_o  <= 4'd0;
      m0_dat_o   <= 32'd0;
      m0_ack_o   <= 1'b0;
      m0_err_o   <= 1'b0;
      m1_dat_o   <= 32'd0;
      m1_ack_o   <= 1'b0;
      m1_err_o   <= 1'b0;
    end else begin
      m0_ack_o <= 1'b0;
      m0_err_o <= 1'b0;
      m1_ack_o <= 1'b0;
      m1_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant      <= pick;
            last_grant <= pick;
            wbs_adr_o  <= pick ? m1_adr_i : m0_adr_i;
            wbs_dat_o  <= pick ? m1_dat_i : m0_dat_i;
            wbs_we_o   <= pick ? m1_we_i  : m0_we_i;
            wbs_sel_o  <= pick ? m1_sel_i : m0_sel_i;
            wbs_cyc_o  <= 1'b1;
            wbs_stb_o  <= 1'b1;
            wait_cnt   <= 16'd0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (!grant_cyc) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbs_we_o  <= 1'b0;
            state     <= IDLE;
          end else if (wbs_ack_i) begin
            if (grant) begin
              m1_dat_o <= wbs_dat_i;
              m1_ack_o <= 1'b1;
            end else begin
              m0_dat_o <= wbs_dat_i;
              m0_ack_o <= 1'b1;
            end
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbs_we_o  <= 1'b0;
            state     <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            if (grant) begin
              m1_dat_o <= 32'd0;
              m1_err_o <= 1'b1;
            end else begin
              m0_dat_o <= 32'd0;
              m0_err_o <= 1'b1;
            end
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbs_we_o  <= 1'b0;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_scr1_arbiter.sv
// tb/tb_wb_scr1_arbiter.sv - self-checking bench for wb_scr1_arbiter
// Honours WB_SCR1_ARB_RR_EN when choosing the expected grant.
module tb_wb_scr1_arbiter;

  localparam int TMO = 4;
`ifdef WB_SCR1_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
  logic [31:0] m0_adr_i = '0, m0_dat_i = '0;
  logic [3:0]  m0_sel_i = '0;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
  logic [31:0] m1_adr_i = '0, m1_dat_i = '0;
  logic [3:0]  m1_sel_i = '0;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [31:0] wbs_adr_o, wbs_dat_o;
  logic [3:0]  wbs_sel_o;
  logic [31:0] wbs_dat_i = '0;
  logic        wbs_ack_i = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_dat [2];
  bit          exp_last;

  wb_scr1_arbiter #(.TIMEOUT(TMO)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .m0_cyc_i (m0_cyc_i),
    .m0_stb_i (m0_stb_i),
    .m0_we_i  (m0_we_i),
    .m0_adr_i (m0_adr_i),
    .m0_dat_i (m0_dat_i),
    .m0_sel_i (m0_sel_i),
    .m0_dat_o (m0_dat_o),
    .m0_ack_o (m0_ack_o),
    .m0_err_o (m0_err_o),
    .m1_cyc_i (m1_cyc_i),
    .m1_stb_i (m1_stb_i),
    .m1_we_i  (m1_we_i),
    .m1_adr_i (m1_adr_i),
    .m1_dat_i (m1_dat_i),
    .m1_sel_i (m1_sel_i),
    .m1_dat_o (m1_dat_o),
    .m1_ack_o (m1_ack_o),
    .m1_err_o (m1_err_o),
    .wbs_cyc_o(wbs_cyc_o),
    .wbs_stb_o(wbs_stb_o),
    .wbs_we_o (wbs_we_o),
    .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o),
    .wbs_sel_o(wbs_sel_o),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_i(wbs_ack_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] terms();
    return 32'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
  endfunction

  // One complete transfer from IDLE; the slave acks in BUSY cycle dly+1.
  task automatic do_txn(input bit r0, input bit r1, input int dly,
                        input logic [31:0] a0, input logic [31:0] rd,
                        input logic w0, input logic [3:0] s0);
    logic [31:0] d0, d1, a1;
    logic        w1;
    logic [3:0]  s1;
    bit          g, acked;
    int          busy, exp_busy;
    d0 = $urandom; d1 = $urandom; a1 = ~a0; w1 = ~w0; s1 = ~s0;
    m0_cyc_i = r0; m0_stb_i = r0; m0_adr_i = a0; m0_dat_i = d0; m0_we_i = w0; m0_sel_i = s0;
    m1_cyc_i = r1; m1_stb_i = r1; m1_adr_i = a1; m1_dat_i = d1; m1_we_i = w1; m1_sel_i = s1;
    g = (r0 && r1) ? (RR ? ~exp_last : 1'b1) : r1;
    exp_last = g;
    @(negedge wb_clk_i);
    chk("grant_cyc", 32'(wbs_cyc_o), 32'd1);
    chk("grant_stb", 32'(wbs_stb_o), 32'd1);
    chk("grant_adr", wbs_adr_o, g ? a1 : a0);
    chk("grant_dat", wbs_dat_o, g ? d1 : d0);
    chk("grant_we_sel", 32'({wbs_we_o, wbs_sel_o}), 32'(g ? {w1, s1} : {w0, s0}));
    busy = 0;
    while (wbs_cyc_o === 1'b1 && busy < 64) begin
      busy++;
      wbs_ack_i = (busy == dly + 1);
      wbs_dat_i = rd;
      @(negedge wb_clk_i);
    end
    wbs_ack_i = 1'b0;
    wbs_dat_i = $urandom;
    acked = (dly + 1 <= TMO);
    exp_busy = acked ? dly + 1 : TMO;
    exp_dat[g] = acked ? rd : 32'h0;
    chk("busy_len", 32'(busy), 32'(exp_busy));
    chk("resp_term", terms(), 32'(g ? {2'b00, acked, ~acked} : {acked, ~acked, 2'b00}));
    chk("resp_m0_dat", m0_dat_o, exp_dat[0]);
    chk("resp_m1_dat", m1_dat_o, exp_dat[1]);
    chk("resp_we", 32'(wbs_we_o), 32'd0);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    @(negedge wb_clk_i);
    chk("idle_term", terms(), 32'd0);
    chk("idle_cyc", 32'(wbs_cyc_o), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, rd;
    int unsigned r;

    // Asynchronous reset: outputs must clear before any clock edge.
    #1 wb_rst_i = 1'b1;
    #1;
    chk("rst_cyc", 32'(wbs_cyc_o), 32'd0);
    chk("rst_adr", wbs_adr_o, 32'd0);
    chk("rst_dat", {m0_dat_o ^ m1_dat_o} | m0_dat_o, 32'd0);
    chk("rst_term", terms(), 32'd0);
    exp_dat[0] = 32'd0; exp_dat[1] = 32'd0; exp_last = 1'b0;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    // Stray slave ack while idle is ignored.
    wbs_ack_i = 1'b1; wbs_dat_i = 32'h1234_5678;
    @(negedge wb_clk_i);
    wbs_ack_i = 1'b0;
    @(negedge wb_clk_i);
    chk("stray_ack_term", terms(), 32'd0);
    chk("stray_ack_dat", m0_dat_o | m1_dat_o, 32'd0);

    // m0 read, ack two cycles after strobe.
    do_txn(1'b1, 1'b0, 2, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 4'hF);

    // Four simultaneous requests, each acked immediately.
    for (int i = 0; i < 4; i++) do_txn(1'b1, 1'b1, 0, $urandom, $urandom, 1'b1, 4'h3);

    // m1 write sel=F, slave never acks -> timeout.
    do_txn(1'b0, 1'b1, 99, $urandom, 32'hCAFE_F00D, 1'b0, 4'h0);

    // Ack in the last BUSY cycle beats the timeout.
    do_txn(1'b0, 1'b1, TMO - 1, $urandom, 32'h0BAD_CAFE, 1'b1, 4'h5);

    // Reset between edges while BUSY.
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0200;
    @(negedge wb_clk_i);
    chk("prerst_cyc", 32'(wbs_cyc_o), 32'd1);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("midrst_cyc", 32'(wbs_cyc_o), 32'd0);
    chk("midrst_dat", m0_dat_o | m1_dat_o, 32'd0);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    exp_dat[0] = 32'd0; exp_dat[1] = 32'd0; exp_last = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    chk("postrst_term", terms(), 32'd0);
    do_txn(1'b1, 1'b0, 1, 32'h0000_0300, 32'h5555_AAAA, 1'b0, 4'h1);

    // m0 aborts in its 2nd BUSY cycle; waiting m1 is granted next.
    ra = 32'h0000_0400; rb = 32'h0000_0800; rd = 32'h7777_1111;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = ra;
    @(negedge wb_clk_i);
    chk("abort_grant_adr", wbs_adr_o, ra);
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = rb;
    @(negedge wb_clk_i);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    @(negedge wb_clk_i);
    chk("abort_cyc", 32'(wbs_cyc_o), 32'd0);
    chk("abort_term", terms(), 32'd0);
    @(negedge wb_clk_i);
    chk("abort_m1_cyc", 32'(wbs_cyc_o), 32'd1);
    chk("abort_m1_adr", wbs_adr_o, rb);
    wbs_ack_i = 1'b1; wbs_dat_i = rd;
    @(negedge wb_clk_i);
    wbs_ack_i = 1'b0;
    exp_dat[1] = rd; exp_last = 1'b1;
    chk("abort_m1_term", terms(), 32'b0010);
    chk("abort_m1_dat", m1_dat_o, exp_dat[1]);
    chk("abort_m0_dat", m0_dat_o, exp_dat[0]);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    @(negedge wb_clk_i);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(1, 3);
      do_txn(r[0], r[1], $urandom_range(0, 6), $urandom, $urandom, 1'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
